// File: rtl/transport_control.sv
// Transport control for a media player: conditions four raw buttons and drives a
// downstream Timer through a registered play/pause/stop/seek state machine.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   play_btn     raw play/pause button (async, active-high)
//   stop_btn     raw stop button (async, active-high)
//   fwd_btn      raw fast-forward button, hold-to-seek
//   rew_btn      raw rewind button, hold-to-seek
//   time_zero    high when the Timer reads 0:00
//   count        Timer count enable
//   adder        signed per-step increment for the Timer
//   timer_reset  one-cycle pulse clearing the Timer
//   state        encoded state: 0 stopped, 1 playing, 2 paused, 3 seek fwd, 4 seek rew
module transport_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned ACCEL_CYCLES    = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play_btn,
    input  logic              stop_btn,
    input  logic              fwd_btn,
    input  logic              rew_btn,
    input  logic              time_zero,
    output logic              count,
    output logic signed [8:0] adder,
    output logic              timer_reset,
    output logic [2:0]        state
);

    localparam logic [2:0] StStopped = 3'd0;
    localparam logic [2:0] StPlaying = 3'd1;
    localparam logic [2:0] StPaused  = 3'd2;
    localparam logic [2:0] StSeekFwd = 3'd3;
    localparam logic [2:0] StSeekRew = 3'd4;

    localparam int unsigned BtnStop = 0;
    localparam int unsigned BtnPlay = 1;
    localparam int unsigned BtnFwd  = 2;
    localparam int unsigned BtnRew  = 3;

    localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HoldW = $clog2(ACCEL_CYCLES + 2);

    localparam logic [DbW-1:0]   DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(ACCEL_CYCLES);

    // ---------------------------------------------------------------
    // Button conditioning: 2-flop synchronizer + counting debouncer
    // ---------------------------------------------------------------
    logic [3:0]          raw;
    logic [3:0]          sync1_q, sync2_q;
    logic [3:0]          level_q;
    logic [3:0]          press_q;   // one-cycle pulse after a debounced rise
    logic [3:0][DbW-1:0] db_cnt_q;

    assign raw = {rew_btn, fwd_btn, play_btn, stop_btn};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            level_q  <= '0;
            press_q  <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                press_q[i] <= 1'b0;
                if (sync2_q[i] != level_q[i]) begin
                    // This sample is the last of the required run: accept the new level.
                    if (db_cnt_q[i] == DbLast) begin
                        level_q[i]  <= sync2_q[i];
                        press_q[i]  <= sync2_q[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Transport state machine
    // ---------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [2:0]        ret_q, ret_d;
    logic [HoldW-1:0]  hold_q, hold_d, hold_inc;
    logic              count_q, count_d;
    logic signed [8:0] adder_q, adder_d;
    logic              timer_reset_q, timer_reset_d;
    logic              fast;

    assign hold_inc = (hold_q == HoldMax) ? hold_q : hold_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        hold_d        = hold_q;
        timer_reset_d = 1'b0;

        // Stop outranks everything; below it, one if/else chain per state means
        // a higher-priority event swallows any lower ones in the same cycle.
        if (press_q[BtnStop]) begin
            state_d       = StStopped;
            timer_reset_d = 1'b1;
        end else begin
            case (state_q)
                StStopped: begin
                    if (press_q[BtnPlay]) state_d = StPlaying;
                end
                StPlaying, StPaused: begin
                    if (press_q[BtnPlay]) begin
                        state_d = (state_q == StPlaying) ? StPaused : StPlaying;
                    end else if (press_q[BtnFwd]) begin
                        state_d = StSeekFwd;
                        ret_d   = state_q;
                        hold_d  = '0;
                    end else if (press_q[BtnRew] && !time_zero) begin
                        state_d = StSeekRew;
                        ret_d   = state_q;
                        hold_d  = '0;
                    end
                end
                StSeekFwd: begin
                    if (!level_q[BtnFwd]) state_d = ret_q;
                    else                  hold_d  = hold_inc;
                end
                StSeekRew: begin
                    // Rewinding past 0:00 is meaningless, so bail out even while held.
                    if (!level_q[BtnRew] || time_zero) state_d = ret_q;
                    else                               hold_d  = hold_inc;
                end
                default: state_d = StStopped;
            endcase
        end
    end

    assign fast = (hold_d >= HoldMax);

    always_comb begin
        count_d = 1'b0;
        adder_d = 9'sd1;
        case (state_d)
            StPlaying: count_d = 1'b1;
            StSeekFwd: begin
                count_d = 1'b1;
                adder_d = fast ? 9'sd15 : 9'sd8;
            end
            StSeekRew: begin
                count_d = 1'b1;
                adder_d = fast ? -9'sd30 : -9'sd10;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StStopped;
            ret_q         <= StPaused;
            hold_q        <= '0;
            count_q       <= 1'b0;
            adder_q       <= 9'sd1;
            timer_reset_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ret_q         <= ret_d;
            hold_q        <= hold_d;
            count_q       <= count_d;
            adder_q       <= adder_d;
            timer_reset_q <= timer_reset_d;
        end
    end

    assign state       = state_q;
    assign count       = count_q;
    assign adder       = adder_q;
    assign timer_reset = timer_reset_q;

endmodule

// File: tb/tb_transport_control.sv
// Self-checking bench for transport_control. A behavioural model (delay line plus
// sliding-window debounce and seek-cycle counting) predicts every output each cycle;
// scenario tasks add directed checks with hand-derived constants.
module tb_transport_control;

    localparam int DB = 4;
    localparam int AC = 100;

    localparam logic signed [8:0] AddOne    = 9'sd1;
    localparam logic signed [8:0] AddRw     = -9'sd10;
    localparam logic signed [8:0] AddRwFast = -9'sd30;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        btns;       // [0] stop, [1] play, [2] fwd, [3] rew
    logic              time_zero;
    logic              count;
    logic signed [8:0] adder;
    logic              timer_reset;
    logic [2:0]        state;

    wire stop_btn = btns[0];
    wire play_btn = btns[1];
    wire fwd_btn  = btns[2];
    wire rew_btn  = btns[3];

    always #5 clk = ~clk;

    transport_control #(
        .DEBOUNCE_CYCLES(DB),
        .ACCEL_CYCLES   (AC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .play_btn   (play_btn),
        .stop_btn   (stop_btn),
        .fwd_btn    (fwd_btn),
        .rew_btn    (rew_btn),
        .time_zero  (time_zero),
        .count      (count),
        .adder      (adder),
        .timer_reset(timer_reset),
        .state      (state)
    );

    int compares = 0;
    int mism     = 0;

    // ---------------- reference model ----------------
    logic [2:0]        m_state, m_ret;
    logic              m_count, m_tr;
    logic signed [8:0] m_adder;
    int                m_seek_n;         // cycles spent in the current seek, 1-based
    logic [3:0]        m_lvl, m_press, m_p1, m_p2;
    logic [3:0]        m_seen[$];        // most recent DB debouncer samples

    task automatic model_update();
        logic [3:0] ev;
        logic [3:0] smp;
        bit         flip;
        if (reset) begin
            m_state = 3'd0; m_count = 1'b0; m_adder = AddOne; m_tr = 1'b0;
            m_ret = 3'd2; m_seek_n = 0;
            m_lvl = '0; m_press = '0; m_p1 = '0; m_p2 = '0;
            m_seen.delete();
        end else begin
            ev   = m_press;
            m_tr = 1'b0;
            if (ev[0]) begin
                m_state = 3'd0;
                m_tr    = 1'b1;
            end else begin
                case (m_state)
                    3'd0: if (ev[1]) m_state = 3'd1;
                    3'd1, 3'd2: begin
                        if (ev[1]) m_state = (m_state == 3'd1) ? 3'd2 : 3'd1;
                        else if (ev[2]) begin
                            m_ret = m_state; m_state = 3'd3; m_seek_n = 1;
                        end else if (ev[3] && !time_zero) begin
                            m_ret = m_state; m_state = 3'd4; m_seek_n = 1;
                        end
                    end
                    3'd3: if (!m_lvl[2]) m_state = m_ret; else m_seek_n++;
                    3'd4: if (!m_lvl[3] || time_zero) m_state = m_ret; else m_seek_n++;
                    default: m_state = 3'd0;
                endcase
            end
            m_count = (m_state == 3'd1) || (m_state == 3'd3) || (m_state == 3'd4);
            case (m_state)
                3'd3:    m_adder = (m_seek_n <= AC) ? 9'sd8 : 9'sd15;
                3'd4:    m_adder = (m_seek_n <= AC) ? AddRw : AddRwFast;
                default: m_adder = AddOne;
            endcase
            // Two-stage synchronizer delay, then accept a level once the last DB
            // samples all disagree with it.
            smp  = m_p2;
            m_p2 = m_p1;
            m_p1 = btns;
            m_seen.push_back(smp);
            if (m_seen.size() > DB) void'(m_seen.pop_front());
            m_press = '0;
            if (m_seen.size() == DB) begin
                for (int b = 0; b < 4; b++) begin
                    flip = 1'b1;
                    foreach (m_seen[k]) if (m_seen[k][b] == m_lvl[b]) flip = 1'b0;
                    if (flip) begin
                        m_lvl[b]   = ~m_lvl[b];
                        m_press[b] = m_lvl[b];
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    function automatic string obs_str();
        return $sformatf("st=%0d cnt=%0b add=%0d tr=%0b", state, count, adder, timer_reset);
    endfunction

    function automatic string exp_str();
        return $sformatf("st=%0d cnt=%0b add=%0d tr=%0b", m_state, m_count, m_adder, m_tr);
    endfunction

    // Stimulus only: one clean press-and-release of button b.
    task automatic tap(input int b);
        btns[b] = 1'b1;
        repeat (6) cycle();
        btns[b] = 1'b0;
        repeat (10) cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        btns = '0; time_zero = 1'b0; reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {3'd0, 1'b0, AddOne, 1'b0}) begin
                mism++;
                $display("FAIL reset cyc=%0d got %s want st=0 cnt=0 add=1 tr=0", i, obs_str());
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}) begin
                mism++;
                $display("FAIL reset_idle cyc=%0d got %s want %s", i, obs_str(), exp_str());
            end
        end
    endtask

    task automatic test_play();
        logic [2:0] want, prev;
        logic       want_cnt;
        for (int p = 0; p < 2; p++) begin
            want     = (p == 0) ? 3'd1 : 3'd2;
            prev     = (p == 0) ? 3'd0 : 3'd1;
            want_cnt = (p == 0);
            btns[1]  = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                cycle();
                compares++;
                if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}) begin
                    mism++;
                    $display("FAIL play_model p=%0d cyc=%0d got %s want %s",
                             p, i, obs_str(), exp_str());
                end
                if (i == 6) begin
                    compares++;
                    if (state !== prev) begin
                        mism++;
                        $display("FAIL play_early p=%0d got st=%0d want st=%0d", p, state, prev);
                    end
                end
                if (i == 7) begin
                    compares++;
                    if ({state, count, adder} !== {want, want_cnt, AddOne}) begin
                        mism++;
                        $display("FAIL play_latency p=%0d got %s want st=%0d cnt=%0b add=1",
                                 p, obs_str(), want, want_cnt);
                    end
                end
                if (i == 10) btns[1] = 1'b0;
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 28; i++) begin
            btns[1] = (i < 20) ? (((i / 2) % 2) == 0) : 1'b0;
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}) begin
                mism++;
                $display("FAIL bounce_model cyc=%0d got %s want %s", i, obs_str(), exp_str());
            end
            compares++;
            if (state !== 3'd2) begin
                mism++;
                $display("FAIL bounce_hold cyc=%0d got st=%0d want st=2", i, state);
            end
        end
    endtask

    task automatic test_fwd_seek();
        int n8 = 0;
        int n15 = 0;
        tap(1);                       // paused -> playing
        btns[2] = 1'b1;
        for (int i = 1; i <= 170; i++) begin
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}) begin
                mism++;
                $display("FAIL fwd_model cyc=%0d got %s want %s", i, obs_str(), exp_str());
            end
            if (state === 3'd3 && adder === 9'sd8)  n8++;
            if (state === 3'd3 && adder === 9'sd15) n15++;
            if (i == 150) btns[2] = 1'b0;
        end
        compares++;
        if (n8 != AC) begin
            mism++;
            $display("FAIL fwd_slow_cycles got %0d want %0d", n8, AC);
        end
        compares++;
        if (n15 != 150 - AC) begin
            mism++;
            $display("FAIL fwd_fast_cycles got %0d want %0d", n15, 150 - AC);
        end
        compares++;
        if ({state, count, adder} !== {3'd1, 1'b1, AddOne}) begin
            mism++;
            $display("FAIL fwd_release got %s want st=1 cnt=1 add=1", obs_str());
        end
    endtask

    task automatic test_rew_zero();
        tap(1);                       // playing -> paused
        btns[3] = 1'b1;
        for (int i = 1; i <= 75; i++) begin
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}) begin
                mism++;
                $display("FAIL rew_model cyc=%0d got %s want %s", i, obs_str(), exp_str());
            end
            if (i >= 7 && i <= 56) begin
                compares++;
                if ({state, count, adder} !== {3'd4, 1'b1, AddRw}) begin
                    mism++;
                    $display("FAIL rew_slow cyc=%0d got %s want st=4 cnt=1 add=-10", i, obs_str());
                end
            end
            if (i > 57) begin
                compares++;
                if (state !== 3'd2) begin
                    mism++;
                    $display("FAIL rew_no_reentry cyc=%0d got st=%0d want st=2", i, state);
                end
            end
            if (i == 57) begin
                compares++;
                if ({state, count, adder} !== {3'd2, 1'b0, AddOne}) begin
                    mism++;
                    $display("FAIL rew_zero_exit got %s want st=2 cnt=0 add=1", obs_str());
                end
                time_zero = 1'b0;
            end
            if (i == 56) time_zero = 1'b1;
        end
        btns[3] = 1'b0;
        repeat (10) cycle();
        // A fresh rew press while already at 0:00 must be ignored.
        time_zero = 1'b1;
        for (int i = 0; i < 20; i++) begin
            btns[3] = (i < 10);
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}
                || state !== 3'd2) begin
                mism++;
                $display("FAIL rew_at_zero cyc=%0d got %s want %s", i, obs_str(), exp_str());
            end
        end
        time_zero = 1'b0;
    endtask

    task automatic test_stop_play();
        int n_tr = 0;
        btns[2] = 1'b1;
        repeat (12) cycle();
        compares++;
        if (state !== 3'd3) begin
            mism++;
            $display("FAIL stop_setup got st=%0d want st=3", state);
        end
        btns[0] = 1'b1;
        btns[1] = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}) begin
                mism++;
                $display("FAIL stop_model cyc=%0d got %s want %s", j, obs_str(), exp_str());
            end
            if (timer_reset === 1'b1) n_tr++;
            if (j == 7) begin
                compares++;
                if ({state, count, timer_reset} !== {3'd0, 1'b0, 1'b1}) begin
                    mism++;
                    $display("FAIL stop_edge got %s want st=0 cnt=0 tr=1", obs_str());
                end
            end
            if (j == 8) btns = '0;
        end
        compares++;
        if (n_tr != 1) begin
            mism++;
            $display("FAIL stop_pulse_width got %0d want 1", n_tr);
        end
        compares++;
        if (state !== 3'd0) begin
            mism++;
            $display("FAIL stop_final got st=%0d want st=0", state);
        end
    endtask

    task automatic test_reset_mid_seek();
        tap(1);                       // stopped -> playing
        btns[3] = 1'b1;
        for (int i = 1; i <= 115; i++) begin
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}) begin
                mism++;
                $display("FAIL rstseek_model cyc=%0d got %s want %s", i, obs_str(), exp_str());
            end
        end
        compares++;
        if ({state, adder} !== {3'd4, AddRwFast}) begin
            mism++;
            $display("FAIL rstseek_fast got %s want st=4 add=-30", obs_str());
        end
        reset   = 1'b1;
        btns[3] = 1'b0;
        btns[1] = 1'b1;               // held through reset release
        cycle();
        compares++;
        if ({state, count, adder, timer_reset} !== {3'd0, 1'b0, AddOne, 1'b0}) begin
            mism++;
            $display("FAIL rstseek_reset got %s want st=0 cnt=0 add=1 tr=0", obs_str());
        end
        repeat (2) cycle();
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}) begin
                mism++;
                $display("FAIL held_model cyc=%0d got %s want %s", i, obs_str(), exp_str());
            end
            if (i == 6 || i == 7) begin
                compares++;
                if (state !== ((i == 7) ? 3'd1 : 3'd0)) begin
                    mism++;
                    $display("FAIL held_press cyc=%0d got st=%0d want st=%0d",
                             i, state, (i == 7) ? 1 : 0);
                end
            end
            if (i == 10) btns[1] = 1'b0;
        end
    endtask

    task automatic test_random();
        int dur[4];
        for (int b = 0; b < 4; b++) dur[b] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if (dur[b] == 0) begin
                    if (b == 0) btns[b] = ($urandom_range(0, 3) == 0);
                    else        btns[b] = 1'($urandom_range(0, 1));
                    if (b == 0)                dur[b] = btns[b] ? $urandom_range(1, 8)
                                                                : $urandom_range(50, 400);
                    else if (b >= 2 && btns[b]) dur[b] = $urandom_range(1, 160);
                    else                       dur[b] = $urandom_range(1, 12);
                end
                dur[b]--;
            end
            time_zero = ($urandom_range(0, 127) == 0);
            reset     = ($urandom_range(0, 999) == 0);
            cycle();
            compares++;
            if ({state, count, adder, timer_reset} !== {m_state, m_count, m_adder, m_tr}) begin
                mism++;
                $display("FAIL random_model cyc=%0d got %s want %s", i, obs_str(), exp_str());
            end
        end
        reset = 1'b0; btns = '0; time_zero = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        btns      = '0;
        time_zero = 1'b0;
        @(negedge clk);
        test_reset();
        test_play();
        test_bounce();
        test_fwd_seek();
        test_rew_zero();
        test_stop_play();
        test_reset_mid_seek();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mism);
        $finish;
    end

endmodule

// File: doc/transport_control.md
TRANSPORT_CONTROL -- requirements
Module: transport_control

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required before a button level change is accepted.
REQ-002 Parameter ACCEL_CYCLES, default 100: cycles a seek button must stay held before the seek speed steps up.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 play_btn  input  1  raw asynchronous play/pause button, active-high.
REQ-007 stop_btn  input  1  raw asynchronous stop button, active-high.
REQ-008 fwd_btn  input  1  raw asynchronous fast-forward button, active-high, hold-to-seek.
REQ-009 rew_btn  input  1  raw asynchronous rewind button, active-high, hold-to-seek.
REQ-010 time_zero  input  1  high when the downstream Timer reads 0:00.
REQ-011 count  output  1  Timer count enable.
REQ-012 adder  output  9  signed two's-complement increment applied by the Timer per step.
REQ-013 timer_reset  output  1  one-cycle pulse that clears the Timer.
REQ-014 state  output  3  encoded FSM state: STOPPED=0, PLAYING=1, PAUSED=2, SEEK_FWD=3, SEEK_REW=4.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose output flips only after DEBOUNCE_CYCLES consecutive identical synchronized samples differing from its current level.
REQ-016 A press event SHALL be the cycle in which a debounced level rises; releases are level-based.
REQ-017 All outputs SHALL be registered; state, count, adder and timer_reset update on the same edge, one cycle after the press event. Raw high to output change SHALL total exactly DEBOUNCE_CYCLES+3 edges.
REQ-018 Simultaneous press events SHALL be prioritized stop > play > fwd > rew; lower-priority events in that cycle are discarded.
REQ-019 Stop press from any state -> STOPPED, count=0, adder=+1, timer_reset=1 for exactly one cycle.
REQ-020 Play press: STOPPED->PLAYING, PLAYING->PAUSED, PAUSED->PLAYING; ignored in SEEK_FWD/SEEK_REW.
REQ-021 PLAYING: count=1, adder=+1. PAUSED and STOPPED: count=0, adder=+1.
REQ-022 fwd press in PLAYING or PAUSED -> SEEK_FWD; rew press in PLAYING or PAUSED -> SEEK_REW; both ignored in STOPPED. The originating state SHALL be stored as return state.
REQ-023 SEEK_FWD: count=1, adder=+8 for the first ACCEL_CYCLES cycles, then +15 until release.
REQ-024 SEEK_REW: count=1, adder=-10 for the first ACCEL_CYCLES cycles, then -30 until release.
REQ-025 Hold counter SHALL saturate at ACCEL_CYCLES and clear on every seek entry.
REQ-026 Debounced release of the active seek button -> return state with its REQ-021 outputs on the next edge.
REQ-027 While in a seek state, presses of the other seek button and play SHALL be ignored; stop still applies.
REQ-028 SEEK_REW with time_zero=1 SHALL exit to the return state on the next edge, even while rew_btn is held; a new rew press is required to re-enter.
REQ-029 rew press while time_zero=1 SHALL be ignored.
REQ-030 Unused state encodings SHALL recover to STOPPED on the next edge.

Reset
REQ-031 While reset=1 at a clock edge: state=STOPPED, count=0, adder=+1, timer_reset=0, return state=PAUSED, hold counter=0, synchronizers and debounced levels=0.
REQ-032 A button held through reset deassertion SHALL produce a press event only after DEBOUNCE_CYCLES stable samples following reset release.

Verification
REQ-033 Reset, then play_btn high for 10 cycles -> state=1, count=1, adder=+1 exactly 7 edges after first high sample; second play press -> state=2, count=0.
REQ-034 play_btn toggled every 2 cycles for 20 cycles -> no state change (bounce rejected).
REQ-035 In PLAYING, hold fwd_btn 150 cycles -> adder=+8 for 100 cycles then +15; release -> state=1, adder=+1.
REQ-036 In PAUSED, hold rew_btn, assert time_zero after 50 cycles -> adder=-10 until then, next edge state=2, count=0, adder=+1 with rew still held.
REQ-037 stop_btn and play_btn rise on the same cycle during SEEK_FWD -> state=0, count=0, timer_reset high exactly one cycle.
REQ-038 reset asserted mid-SEEK_REW with adder=-30 -> next edge state=0, count=0, adder=+1, timer_reset=0.
